avg_channel_sequencer: RTL and testbench

- Sequences the 8-bit ADC-to-moving-average path across NUM_CH multiplexed analog channels.
- On every channel change it clears the external averager and discards settling samples.
- It then forwards samples until the 2^POWER-deep window is completely refilled, and only then publishes averaged results.
- It sits between the ADC front-end (ready pulse plus data) and the averager instance, and drives the analog mux select.

---
 rtl/avg_seq_pkg.sv | 21 ++
 rtl/sample_gate_cnt.sv | 44 ++++
 rtl/avg_channel_sequencer.sv | 167 ++++++++++++++++
 tb/tb_avg_channel_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_seq_pkg.sv
// Shared types and constants for the ADC-to-averager channel sequencer.
// Sequencer states, averager data widths and the counter-width helper.
package avg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SETTLE,
    FILL,
    RUN
  } seq_state_t;

  localparam int AVG_DATA_W = 8;
  localparam int AVG_OUT_W  = 16;

  // Bits needed to hold 0..limit inclusive; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sample_gate_cnt.sv
// Counted pulse gate: counts accepted pulses up to LIMIT and then saturates.
// hit_o flags the pulse that reaches LIMIT; done_o stays high once there.
module sample_gate_cnt
  import avg_seq_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic pulse_i,
  output logic hit_o,
  output logic done_o
);

  localparam int CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (pulse_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TERM);
  assign hit_o  = pulse_i && !clr_i && !done_o && (cnt_q == LAST);

endmodule

// File: rtl/avg_channel_sequencer.sv
// Sequences the ADC-to-moving-average path across multiplexed channels:
// flush the averager on channel change, discard settling samples, refill, then publish.
module avg_channel_sequencer
  import avg_seq_pkg::*;
#(
  parameter int POWER          = 8,
  parameter int SETTLE_SAMPLES = 4,
  parameter int NUM_CH         = 4,
  parameter int CH_W           = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [CH_W-1:0]       ch_req,
  input  logic                  adc_ready,
  input  logic [AVG_DATA_W-1:0] adc_data,
  input  logic [AVG_OUT_W-1:0]  avg_q,
  output logic [CH_W-1:0]       adc_ch,
  output logic                  avg_clr,
  output logic                  avg_en,
  output logic [AVG_DATA_W-1:0] avg_din,
  output logic [AVG_OUT_W-1:0]  result,
  output logic [CH_W-1:0]       result_ch,
  output logic                  result_valid,
  output logic                  result_stb,
  output logic                  ch_err
);

  localparam int FILL_DEPTH = 1 << POWER;

  seq_state_t state_q;
  seq_state_t state_d;

  logic req_valid;
  logic ch_change;
  logic settle_hit;
  logic settle_done;
  logic fill_hit;
  logic fill_done;

  logic drop;
  logic settle_pulse;
  logic fwd;
  logic eligible;
  logic capture;
  logic ch_err_d;

  logic [CH_W-1:0]       adc_ch_q;
  logic                  avg_en_q;
  logic [AVG_DATA_W-1:0] avg_din_q;
  logic                  tag_q;
  logic                  pend_q;
  logic [AVG_OUT_W-1:0]  result_q;
  logic [CH_W-1:0]       result_ch_q;
  logic                  result_valid_q;
  logic                  result_stb_q;
  logic                  ch_err_q;

  assign req_valid = (int'(ch_req) < NUM_CH);
  assign ch_change = req_valid && (ch_req != adc_ch_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = FLUSH;
      FLUSH:   state_d = (SETTLE_SAMPLES == 0) ? FILL : SETTLE;
      SETTLE:  if (settle_hit || settle_done) state_d = FILL;
      FILL:    if (fill_hit || fill_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    // Enable drop beats a channel change, and both beat the normal progression.
    if (state_q != IDLE && !enable) begin
      state_d = IDLE;
    end else if ((state_q == SETTLE || state_q == FILL || state_q == RUN) && ch_change) begin
      state_d = FLUSH;
    end
  end

  always_comb begin
    avg_clr      = (state_q == FLUSH);
    drop         = (state_d == IDLE) || (state_d == FLUSH);
    settle_pulse = adc_ready && (state_q == SETTLE) && !drop;
    fwd          = adc_ready && (state_q == FILL || state_q == RUN) && !drop;
    eligible     = (state_q == RUN) || fill_hit;
    capture      = pend_q && !drop;
    ch_err_d     = (state_q != IDLE) && !req_valid;
  end

  sample_gate_cnt #(
    .LIMIT (SETTLE_SAMPLES)
  ) u_settle_gate (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (avg_clr),
    .pulse_i (settle_pulse),
    .hit_o   (settle_hit),
    .done_o  (settle_done)
  );

  sample_gate_cnt #(
    .LIMIT (FILL_DEPTH)
  ) u_fill_gate (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (avg_clr),
    .pulse_i (fwd),
    .hit_o   (fill_hit),
    .done_o  (fill_done)
  );

  // tag_q/pend_q track a capture-eligible sample through the averager's two-cycle path.
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_ch_q       <= '0;
      avg_en_q       <= 1'b0;
      avg_din_q      <= '0;
      tag_q          <= 1'b0;
      pend_q         <= 1'b0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      result_stb_q   <= 1'b0;
      ch_err_q       <= 1'b0;
    end else begin
      if (state_q == FLUSH && req_valid) begin
        adc_ch_q <= ch_req;
      end
      avg_en_q <= fwd;
      if (fwd) begin
        avg_din_q <= adc_data;
      end
      tag_q        <= fwd && eligible;
      pend_q       <= tag_q && !drop;
      result_stb_q <= capture;
      if (capture) begin
        result_q    <= avg_q;
        result_ch_q <= adc_ch_q;
      end
      if (drop) begin
        result_valid_q <= 1'b0;
      end else if (capture) begin
        result_valid_q <= 1'b1;
      end
      ch_err_q <= ch_err_d;
    end
  end

  assign adc_ch       = adc_ch_q;
  assign avg_en       = avg_en_q;
  assign avg_din      = avg_din_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign result_stb   = result_stb_q;
  assign ch_err       = ch_err_q;

endmodule

// File: tb/tb_avg_channel_sequencer.sv
// Directed bench for avg_channel_sequencer with a behavioural 16-deep moving averager.
// NUM_CH=6 so that index 7 fits in CH_W bits yet is out of range.
module tb_avg_channel_sequencer;

  localparam int POWER  = 4;
  localparam int SETTLE = 2;
  localparam int NUM_CH = 6;
  localparam int CH_W   = $clog2(NUM_CH);

  logic            clk;
  logic            reset;
  logic            enable;
  logic [CH_W-1:0] ch_req;
  logic            adc_ready;
  logic [7:0]      adc_data;
  logic [15:0]     avg_q;
  logic [CH_W-1:0] adc_ch;
  logic            avg_clr;
  logic            avg_en;
  logic [7:0]      avg_din;
  logic [15:0]     result;
  logic [CH_W-1:0] result_ch;
  logic            result_valid;
  logic            result_stb;
  logic            ch_err;

  int n_chk = 0;
  int n_err = 0;
  int n_en  = 0;
  int n_stb = 0;
  int n_clr = 0;
  int n_cer = 0;

  avg_channel_sequencer #(
    .POWER          (POWER),
    .SETTLE_SAMPLES (SETTLE),
    .NUM_CH         (NUM_CH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ch_req       (ch_req),
    .adc_ready    (adc_ready),
    .adc_data     (adc_data),
    .avg_q        (avg_q),
    .adc_ch       (adc_ch),
    .avg_clr      (avg_clr),
    .avg_en       (avg_en),
    .avg_din      (avg_din),
    .result       (result),
    .result_ch    (result_ch),
    .result_valid (result_valid),
    .result_stb   (result_stb),
    .ch_err       (ch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External averager: registered window sum, cleared by reset|avg_clr.
  logic [7:0]  win [16];
  logic [11:0] acc;
  always @(posedge clk) begin
    if (reset || avg_clr) begin
      acc <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (avg_en) begin
      acc    <= acc + 12'(avg_din) - 12'(win[15]);
      win[0] <= avg_din;
      for (int i = 1; i < 16; i++) win[i] <= win[i-1];
    end
  end
  assign avg_q = {acc, 4'h0};

  always @(negedge clk) begin
    if (avg_en)     n_en  <= n_en + 1;
    if (result_stb) n_stb <= n_stb + 1;
    if (avg_clr)    n_clr <= n_clr + 1;
    if (ch_err)     n_cer <= n_cer + 1;
  end

  typedef struct {
    logic [7:0]  data;
    bit          exp_en;
    logic [3:0]  exp_stb;
    bit          exp_valid;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs [34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ADC pulse at cycle t, then three quiet cycles; strobe sampled at t+1..t+4.
  task automatic pulse(input logic [7:0] d, output bit en, output logic [7:0] din,
                       output logic [3:0] stb, output logic [15:0] res,
                       output bit vld, output logic [CH_W-1:0] rch);
    adc_ready = 1'b1;
    adc_data  = d;
    tick();
    en     = avg_en;
    din    = avg_din;
    stb[0] = result_stb;
    adc_ready = 1'b0;
    tick();
    stb[1] = result_stb;
    tick();
    stb[2] = result_stb;
    res    = result;
    vld    = result_valid;
    rch    = result_ch;
    tick();
    stb[3] = result_stb;
  endtask

  bit              p_en;
  logic [7:0]      p_din;
  logic [3:0]      p_stb;
  logic [15:0]     p_res;
  bit              p_vld;
  logic [CH_W-1:0] p_rch;
  int              snap_en;
  int              snap_stb;
  int              snap_clr;

  initial begin
    // Table for channel 2: 2 settle, 16 fill of 0x80, 16 run alternating 0x10/0x20.
    for (int i = 0; i < 34; i++) begin
      vecs[i].data      = 8'h80;
      vecs[i].exp_en    = (i >= SETTLE);
      vecs[i].exp_stb   = 4'b0000;
      vecs[i].exp_valid = 1'b0;
      vecs[i].exp_res   = 16'h0000;
    end
    vecs[17].exp_stb   = 4'b0100;
    vecs[17].exp_valid = 1'b1;
    vecs[17].exp_res   = 16'h8000;
    for (int k = 1; k <= 16; k++) begin
      vecs[17+k].data      = (k % 2 == 1) ? 8'h10 : 8'h20;
      vecs[17+k].exp_stb   = 4'b0100;
      vecs[17+k].exp_valid = 1'b1;
      vecs[17+k].exp_res   = 16'(((16 - k) * 128 + ((k + 1) / 2) * 16 + (k / 2) * 32) * 16);
    end

    reset = 1'b1; enable = 1'b0; ch_req = '0; adc_ready = 1'b0; adc_data = '0;
    repeat (3) tick();
    check("rst_adc_ch",  32'(adc_ch), 0);
    check("rst_avg_clr", 32'(avg_clr), 0);
    check("rst_avg_en",  32'(avg_en), 0);
    check("rst_avg_din", 32'(avg_din), 0);
    check("rst_result",  32'(result), 0);
    check("rst_res_ch",  32'(result_ch), 0);
    check("rst_valid",   32'(result_valid), 0);
    check("rst_stb",     32'(result_stb), 0);
    check("rst_ch_err",  32'(ch_err), 0);

    reset = 1'b0;
    tick();
    check("idle_no_clr", 32'(avg_clr), 0);
    enable = 1'b1; ch_req = 3'd1;
    tick();
    check("flush_clr", 32'(avg_clr), 1);
    tick();
    check("flush_ch1",   32'(adc_ch), 1);
    check("flush_once",  32'(n_clr), 1);

    // Channel 1: settle and a partial fill, then switch to 2 together with a pulse.
    for (int i = 0; i < 7; i++) begin
      pulse(8'h80, p_en, p_din, p_stb, p_res, p_vld, p_rch);
      check($sformatf("c1_p%0d_en", i), 32'(p_en), (i >= SETTLE) ? 1 : 0);
      check($sformatf("c1_p%0d_stb", i), 32'(p_stb), 0);
    end
    ch_req = 3'd2; adc_ready = 1'b1; adc_data = 8'h77;
    tick();
    adc_ready = 1'b0;
    check("swap_no_en", 32'(avg_en), 0);
    check("swap_clr",   32'(avg_clr), 1);
    tick();
    check("swap_ch2",   32'(adc_ch), 2);
    check("swap_valid", 32'(result_valid), 0);

    for (int i = 0; i < 34; i++) begin
      pulse(vecs[i].data, p_en, p_din, p_stb, p_res, p_vld, p_rch);
      check($sformatf("v%0d_en", i), 32'(p_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) check($sformatf("v%0d_din", i), 32'(p_din), 32'(vecs[i].data));
      check($sformatf("v%0d_stb", i), 32'(p_stb), 32'(vecs[i].exp_stb));
      check($sformatf("v%0d_valid", i), 32'(p_vld), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_res", i), 32'(p_res), 32'(vecs[i].exp_res));
      if (vecs[i].exp_stb != 4'b0000) check($sformatf("v%0d_rch", i), 32'(p_rch), 2);
    end

    // Out-of-range request in RUN: flagged, ignored, results keep flowing.
    ch_req = 3'd7; adc_ready = 1'b1; adc_data = 8'h10;
    tick();
    ch_req = 3'd2; adc_ready = 1'b0;
    check("err_pulse", 32'(ch_err), 1);
    check("err_en",    32'(avg_en), 1);
    check("err_ch",    32'(adc_ch), 2);
    tick();
    check("err_once",  32'(ch_err), 0);
    tick();
    check("err_stb",   32'(result_stb), 1);
    check("err_res",   32'(result), 'h1800);
    check("err_valid", 32'(result_valid), 1);
    tick();
    check("err_count", 32'(n_cer), 1);

    // Pending capture cancelled by a channel change one cycle after the pulse.
    snap_stb = n_stb;
    snap_clr = n_clr;
    adc_ready = 1'b1; adc_data = 8'h20;
    tick();
    adc_ready = 1'b0; ch_req = 3'd3;
    tick();
    check("cancel_clr",   32'(avg_clr), 1);
    check("cancel_valid", 32'(result_valid), 0);
    tick();
    check("cancel_ch3",   32'(adc_ch), 3);
    repeat (3) tick();
    check("cancel_no_stb", 32'(n_stb), 32'(snap_stb));
    check("cancel_clr1",   32'(n_clr), 32'(snap_clr + 1));
    check("cancel_held",   32'(result), 'h1800);

    // Refill channel 3 with 0x40, then drop enable in RUN together with a pulse.
    for (int i = 0; i < SETTLE + 16; i++) begin
      pulse(8'h40, p_en, p_din, p_stb, p_res, p_vld, p_rch);
      if (i == SETTLE + 14) check("c3_not_yet", 32'(p_vld), 0);
    end
    check("c3_stb",   32'(p_stb), 'b0100);
    check("c3_res",   32'(p_res), 'h4000);
    check("c3_rch",   32'(p_rch), 3);
    check("c3_valid", 32'(p_vld), 1);
    snap_en  = n_en;
    snap_stb = n_stb;
    enable = 1'b0; adc_ready = 1'b1; adc_data = 8'h11;
    tick();
    adc_ready = 1'b0;
    check("off_no_en", 32'(avg_en), 0);
    check("off_valid", 32'(result_valid), 0);
    check("off_held",  32'(result), 'h4000);
    for (int i = 0; i < 2; i++) pulse(8'h22, p_en, p_din, p_stb, p_res, p_vld, p_rch);
    check("off_en_cnt",  32'(n_en), 32'(snap_en));
    check("off_stb_cnt", 32'(n_stb), 32'(snap_stb));
    check("off_held2",   32'(result), 'h4000);

    // Re-enable, partially fill, then reset mid-FILL.
    enable = 1'b1;
    tick();
    check("re_clr", 32'(avg_clr), 1);
    tick();
    for (int i = 0; i < SETTLE + 3; i++) pulse(8'h40, p_en, p_din, p_stb, p_res, p_vld, p_rch);
    check("fill_en", 32'(p_en), 1);
    reset = 1'b1;
    tick();
    check("mrst_adc_ch",  32'(adc_ch), 0);
    check("mrst_avg_clr", 32'(avg_clr), 0);
    check("mrst_avg_en",  32'(avg_en), 0);
    check("mrst_avg_din", 32'(avg_din), 0);
    check("mrst_result",  32'(result), 0);
    check("mrst_res_ch",  32'(result_ch), 0);
    check("mrst_valid",   32'(result_valid), 0);
    check("mrst_stb",     32'(result_stb), 0);
    check("mrst_ch_err",  32'(ch_err), 0);
    reset = 1'b0;
    tick();
    check("restart_clr", 32'(avg_clr), 1);
    tick();
    check("restart_ch",  32'(adc_ch), 3);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
